// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the ROB dispatch port.
// Show-ahead FIFO: the head record is driven combinationally and is zeroed while invalid.
module dispatch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TYP_W = 2,
  parameter int unsigned DST_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_dec_valid,
  input  logic [TYP_W-1:0] i_dec_typ,
  input  logic [DST_W-1:0] i_dec_dst,
  output logic             o_dec_ready,
  output logic             o_dq_valid,
  output logic [TYP_W-1:0] o_dq_typ,
  output logic [DST_W-1:0] o_dq_dst,
  input  logic             i_dq_busy,
  output logic [CNT_W-1:0] o_dq_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TYP_W-1:0] typ;
    logic [DST_W-1:0] dst;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  rec_t             head;

  // A full queue refuses pushes even when a pop happens in the same cycle,
  // which keeps i_dq_busy out of the o_dec_ready path.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign o_dec_ready = ~full & ~i_flush;
  assign o_dq_valid  = ~empty & ~i_flush;
  assign push        = i_dec_valid & o_dec_ready;
  assign pop         = o_dq_valid & ~i_dq_busy;
  assign head        = mem[rd_ptr];
  assign o_dq_typ    = o_dq_valid ? head.typ : '0;
  assign o_dq_dst    = o_dq_valid ? head.dst : '0;
  assign o_dq_count  = count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{typ: i_dec_typ, dst: i_dec_dst};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
